// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and defaults for the SRAM arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_INST,
    RESP_DATA
  } resp_owner_t;
  localparam int DEFAULT_STARVE_LIMIT = 4;
endpackage

// File: rtl/sram_arb_starve_cnt.sv
// sram_arb_starve_cnt: saturating count of stalled fetch cycles; starve flags a fetch that has waited LIMIT cycles
module sram_arb_starve_cnt #(
  parameter int LIMIT = sram_arb_pkg::DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_gnt,
  output logic starve
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  // count stalled fetch cycles, clear on grant or withdrawal, hold at the limit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else cnt_q <= (!inst_req || inst_gnt) ? '0 : (cnt_q == W'(LIMIT)) ? cnt_q : cnt_q + 1'b1;
  end
  assign starve = cnt_q == W'(LIMIT);
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between fetch and load/store; SRAM_ARB_STARVE_GUARD_EN enables the fetch starvation guard
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  resp_owner_t resp_q;
  logic starve;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  sram_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .resetn   (resetn),
    .inst_req (inst_req),
    .inst_gnt (inst_gnt),
    .starve   (starve)
  );
`else
  assign starve = 1'b0;
`endif
  assign inst_gnt = inst_req & (starve | ~data_req);
  assign data_gnt = data_req & ~inst_gnt;
  // drive the winner's command onto the SRAM, idle bus is all zeros
  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_wen   = data_gnt ? data_wen : '0;
    sram_addr  = inst_gnt ? inst_addr : data_gnt ? data_addr : '0;
    sram_wdata = data_gnt ? data_wdata : '0;
  end
  // remember who owns the read data arriving next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) resp_q <= RESP_NONE;
    else resp_q <= inst_gnt ? RESP_INST : data_gnt ? RESP_DATA : RESP_NONE;
  end
  assign inst_rvalid = resp_q == RESP_INST;
  assign data_rvalid = resp_q == RESP_DATA;
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM between the CPU's instruction-fetch port and its load/store port. Each cycle it grants the SRAM to at most one requester, drives the SRAM command and routes the read data returned one cycle later back to the requester that issued it. Data accesses normally have priority; a starvation guard bounds how long a fetch can wait. It sits between the CPU top's `inst_sram_*` / `data_sram_*` ports and a unified memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8)
- `STARVE_LIMIT`, 4, consecutive stalled fetch cycles before fetch is forced to win (≥1)

Ports:
- `clk` in 1: the single clock
- `resetn` in 1: reset, asynchronous and active-low
- `inst_req` in 1: fetch request, held until `inst_gnt`
- `inst_addr` in ADDR_W: fetch address
- `inst_gnt` out 1: fetch command issued this cycle
- `inst_rvalid` out 1: fetch data valid on `inst_rdata`
- `inst_rdata` out DATA_W: fetch read data
- `data_req` in 1: load/store request, held until `data_gnt`
- `data_wen` in DATA_W/8: byte write enables (0 = read)
- `data_addr` in ADDR_W: load/store address
- `data_wdata` in DATA_W: store data
- `data_gnt` out 1: load/store command issued this cycle
- `data_rvalid` out 1: load data valid / store complete
- `data_rdata` out DATA_W: load read data
- `sram_en` out 1: SRAM enable
- `sram_wen` out DATA_W/8: SRAM byte write enables
- `sram_addr` out ADDR_W: SRAM address
- `sram_wdata` out DATA_W: SRAM write data
- `sram_rdata` in DATA_W: SRAM read data, valid the cycle after `sram_en`

## Operation
- Arbitration is combinational from `inst_req`, `data_req` and the starvation state. Winner rule: `data_req` wins unless the starvation flag is set, in which case `inst_req` wins. A lone requester always wins.
- The winner gets `*_gnt`=1, and its command drives `sram_*` the same cycle: `sram_en`=1, `sram_wen` = `data_wen` (or 0 for fetch), `sram_addr`/`sram_wdata` from the winner. With no winner, `sram_en`=0, `sram_wen`=0, and addr/wdata are 0.
- Response-owner register `resp_q` has three states: RESP_NONE, RESP_INST and RESP_DATA. At each edge it loads the current winner, or RESP_NONE if there is no grant.
- `inst_rvalid` = (`resp_q`==RESP_INST) and `data_rvalid` = (`resp_q`==RESP_DATA). Both `*_rdata` carry `sram_rdata` unqualified; only `*_rvalid` qualifies them. Stores also produce `data_rvalid`, with rdata don't-care.
- Throughput is one command per cycle. Back-to-back grants, including alternating owners, are legal with no bubble.
- A requester must keep req, addr, wen and wdata stable until it sees gnt. Dropping req before gnt withdraws the request with no side effect.

## Timing
- Grant latency is 0 cycles (same cycle as req when it wins). Read latency is 1 cycle from gnt to rvalid.
- Reset values: `resp_q`=RESP_NONE, starvation counter 0, flag 0. As a result all `*_rvalid`=0, and gnt/`sram_*` follow the requests combinationally.
- If reset asserts mid-operation, the outstanding response is dropped and no rvalid is issued for it. SRAM data arriving after reset is ignored.
- Simultaneous requests with the flag clear: data granted, fetch stalls. With the flag set: fetch granted, data stalls one cycle.
- Starvation counter, with width clog2(STARVE_LIMIT+1):
  - Increments each cycle in which `inst_req`=1 and `inst_gnt`=0. It saturates at STARVE_LIMIT.
  - Clears on `inst_gnt` or when `inst_req`=0.
  - The flag is (counter==STARVE_LIMIT). A fetch therefore waits at most STARVE_LIMIT cycles.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN` defined: the starvation counter and flag are built as described above.
- Not defined: the counter is absent and the flag is constant 0. Arbitration is strict data priority, and fetch may starve indefinitely under continuous `data_req`.

## Structure
- Package `sram_arb_pkg`: the `resp_owner_t` enum (RESP_NONE/RESP_INST/RESP_DATA) and the default `STARVE_LIMIT` constant.
- Sub-module `sram_arb_starve_cnt`: the saturating counter and flag. It is only instantiated under `SRAM_ARB_STARVE_GUARD_EN`.

## Test plan
- Lone fetch: `inst_req`=1, addr 0xBFC00000, `sram_rdata`=0x24080001 next cycle. Required: `inst_gnt`=1 the same cycle with `sram_addr`=0xBFC00000 and `sram_wen`=0; `inst_rvalid`=1 next cycle with `inst_rdata`=0x24080001.
- Store: `data_req`=1, `data_wen`=4'b0011, addr 0x100, wdata 0xDEADBEEF. Required: `sram_wen`=4'b0011, `sram_wdata`=0xDEADBEEF, `data_gnt`=1; `data_rvalid`=1 next cycle, and `inst_rvalid` stays 0.
- Contention, STARVE_LIMIT=4: both req held high continuously. Required: data granted cycles 0–3, fetch granted cycle 4, data cycle 5. With the macro undefined, fetch is never granted.
- Alternating back-to-back: cycle 0 data read, cycle 1 fetch. Required: `data_rvalid` cycle 1 and `inst_rvalid` cycle 2, each carrying the `sram_rdata` value of its own cycle, with no bubble.
- Reset mid-operation: assert `resetn`=0 asynchronously between a fetch gnt and the next edge. Required: `inst_rvalid`=0 immediately, `resp_q`=RESP_NONE, counter 0.
- Withdrawal: `inst_req` high 2 cycles while data wins, then low 1 cycle. Required: counter returns to 0; no `inst_gnt` or `inst_rvalid` appears.
